// File: rtl/cache_sim_pkg.sv
// Shared definitions for the cache simulator front end: command codes,
// address field widths, the trace record type and the legal-command filter.
package cache_sim_pkg;

    localparam logic [3:0] CMD_READ      = 4'd0;
    localparam logic [3:0] CMD_WRITE     = 4'd1;
    localparam logic [3:0] CMD_IFETCH    = 4'd2;
    localparam logic [3:0] CMD_INVAL     = 4'd3;
    localparam logic [3:0] CMD_SNOOP_REQ = 4'd4;
    localparam logic [3:0] CMD_CLEAR     = 4'd8;
    localparam logic [3:0] CMD_PRINT     = 4'd9;

    localparam int TAG_W    = 12;
    localparam int INDEX_W  = 14;
    localparam int OFFSET_W = 6;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] addr;
    } trace_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_CLEAR_WAIT = 2'd2
    } seq_state_t;

    function automatic logic is_legal_cmd(input logic [3:0] cmd);
        logic legal_s;
        case (cmd)
            CMD_READ, CMD_WRITE, CMD_IFETCH, CMD_INVAL,
            CMD_SNOOP_REQ, CMD_CLEAR, CMD_PRINT: legal_s = 1'b1;
            default:                             legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra wrap bit on each pointer to tell full from empty.
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign rdata = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer advance; writes are blocked while full, reads while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop && !empty) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/trace_request_sequencer.sv
// Buffers trace records, filters illegal codes and issues one numbered
// request per handshake to the data cache, with a quiet period after clear-all.
module trace_request_sequencer
    import cache_sim_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_cmd,
    input  logic [31:0]         in_addr,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [3:0]          instruction,
    output logic [TAG_W-1:0]    tag,
    output logic [INDEX_W-1:0]  index,
    output logic [OFFSET_W-1:0] byte_offset,
    output logic [31:0]         iteration,
    output logic                print_stats,
    output logic [15:0]         drop_count,
    output logic                busy
);
    localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);

    trace_rec_t       wr_rec_s;
    trace_rec_t       head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             accept_s;
    logic             push_s;
    logic             load_s;
    logic             hs_s;
    seq_state_t       state_r;
    seq_state_t       state_nxt_s;
    logic [CNT_W-1:0] clr_cnt_r;
    logic [CNT_W-1:0] clr_cnt_nxt_s;
    logic [3:0]       instr_r;
    logic [31:0]      addr_r;
    logic [31:0]      iter_r;
    logic [15:0]      drop_r;

    assign accept_s = in_valid && !fifo_full_s;
    assign push_s   = accept_s && is_legal_cmd(in_cmd);
    assign wr_rec_s = '{cmd: in_cmd, addr: in_addr};
    assign hs_s     = (state_r == ST_ISSUE) && req_ready;

    sync_fifo #(
        .WIDTH ($bits(trace_rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (load_s),
        .wdata (wr_rec_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state logic; load_s pops the FIFO head into the request register.
    // The final quiet cycle may already load, so the gap is exactly CLEAR_CYCLES.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        load_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!hs_s) begin
                    state_nxt_s = ST_ISSUE;
                end else if (instr_r == CMD_CLEAR) begin
                    state_nxt_s   = ST_CLEAR_WAIT;
                    clr_cnt_nxt_s = CNT_W'(CLEAR_CYCLES);
                end else if (!fifo_empty_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR_WAIT: begin
                clr_cnt_nxt_s = clr_cnt_r - CNT_W'(1);
                if (clr_cnt_r != CNT_W'(1)) begin
                    state_nxt_s = ST_CLEAR_WAIT;
                end else if (!fifo_empty_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                clr_cnt_nxt_s = '0;
            end
        endcase
    end

    // State and quiet-period counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            clr_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
        end
    end

    // Request register: holds the presented record until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r <= 4'd0;
            addr_r  <= 32'd0;
        end else if (load_s) begin
            instr_r <= head_s.cmd;
            addr_r  <= head_s.addr;
        end else begin
            instr_r <= instr_r;
            addr_r  <= addr_r;
        end
    end

    // Iteration advances on every request handshake and wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_r <= 32'd0;
        end else if (hs_s) begin
            iter_r <= iter_r + 32'd1;
        end else begin
            iter_r <= iter_r;
        end
    end

    // Saturating count of illegal codes taken at the input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_r <= 16'd0;
        end else if (accept_s && !is_legal_cmd(in_cmd) && (drop_r != 16'hFFFF)) begin
            drop_r <= drop_r + 16'd1;
        end else begin
            drop_r <= drop_r;
        end
    end

    assign in_ready    = !fifo_full_s;
    assign req_valid   = (state_r == ST_ISSUE);
    assign instruction = instr_r;
    assign tag         = addr_r[31:20];
    assign index       = addr_r[19:6];
    assign byte_offset = addr_r[5:0];
    assign iteration   = iter_r;
    assign print_stats = hs_s && (instr_r == CMD_PRINT);
    assign drop_count  = drop_r;
    assign busy        = !fifo_empty_s || (state_r != ST_IDLE);

endmodule

// File: tb/tb_trace_request_sequencer.sv
// Directed bench for trace_request_sequencer: a timestamped queue model checked
// every cycle, plus literal expectations for the decode, filter, clear and wrap cases.
module tb_trace_request_sequencer;
    localparam int DEPTH = 4;
    localparam int CLEAR_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_cmd = 4'd0;
    logic [31:0] in_addr = 32'd0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [3:0]  instruction;
    logic [11:0] tag;
    logic [13:0] index;
    logic [5:0]  byte_offset;
    logic [31:0] iteration;
    logic        print_stats;
    logic [15:0] drop_count;
    logic        busy;

    trace_request_sequencer #(.DEPTH(DEPTH), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_cmd(in_cmd), .in_addr(in_addr), .req_valid(req_valid), .req_ready(req_ready),
        .instruction(instruction), .tag(tag), .index(index), .byte_offset(byte_offset),
        .iteration(iteration), .print_stats(print_stats), .drop_count(drop_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {logic [3:0] cmd; logic [31:0] addr; int vis;} mrec_t;
    typedef struct {logic [3:0] instr; logic [11:0] tag; logic [13:0] index; logic [5:0] off; logic [31:0] iter; int cyc;} hs_t;

    int n_total = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_push_cyc = 0;
    int pcnt = 0;
    hs_t hs_log[$];

    // model: entries become visible the cycle after their push; a request may be
    // presented once its entry is visible and the previous request's release time has come
    mrec_t mq[$];
    mrec_t m_cur;
    bit m_cur_v;
    logic [31:0] m_iter;
    logic [15:0] m_drop;
    int m_next_ok;
    bit e_rdy;
    bit e_busy;
    bit m_hs;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic bit legal(input logic [3:0] c);
        return c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9};
    endfunction

    function automatic hs_t get_hs(input int i);
        hs_t z = '{instr: 4'hF, tag: 12'hFFF, index: 14'h3FFF, off: 6'h3F, iter: 32'hDEAD_BEEF, cyc: -100};
        if (i < hs_log.size()) return hs_log[i];
        return z;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_cur = '{cmd: 4'd0, addr: 32'd0, vis: 0};
            m_cur_v = 1'b0;
            m_iter = 32'd0;
            m_drop = 16'd0;
            m_next_ok = 0;
        end else begin
            e_rdy = (mq.size() < DEPTH);
            e_busy = (mq.size() > 0) || m_cur_v || (cyc < m_next_ok);
            m_hs = m_cur_v && req_ready;
            chk("in_ready", 32'(in_ready), 32'(e_rdy));
            chk("req_valid", 32'(req_valid), 32'(m_cur_v));
            chk("instruction", 32'(instruction), 32'(m_cur.cmd));
            chk("tag", 32'(tag), 32'(m_cur.addr >> 20));
            chk("index", 32'(index), (m_cur.addr >> 6) % 32'd16384);
            chk("byte_offset", 32'(byte_offset), m_cur.addr % 32'd64);
            chk("iteration", iteration, m_iter);
            chk("print_stats", 32'(print_stats), 32'(m_hs && m_cur.cmd == 4'd9));
            chk("drop_count", 32'(drop_count), 32'(m_drop));
            chk("busy", 32'(busy), 32'(e_busy));
            if (req_valid && req_ready)
                hs_log.push_back('{instr: instruction, tag: tag, index: index, off: byte_offset, iter: iteration, cyc: cyc});
            if (print_stats) pcnt++;
            if (m_hs) begin
                m_iter = m_iter + 32'd1;
                m_next_ok = cyc + 1 + ((m_cur.cmd == 4'd8) ? CLEAR_CYCLES : 0);
                m_cur_v = 1'b0;
            end
            if (!m_cur_v && mq.size() > 0 && mq[0].vis <= cyc && cyc + 1 >= m_next_ok) begin
                m_cur = mq.pop_front();
                m_cur_v = 1'b1;
            end
            if (in_valid && e_rdy) begin
                last_push_cyc = cyc;
                if (legal(in_cmd)) mq.push_back('{cmd: in_cmd, addr: in_addr, vis: cyc + 1});
                else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        hs_log.delete();
        pcnt = 0;
    endtask

    task automatic push(input logic [3:0] c, input logic [31:0] a);
        int n = 0;
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_cmd = c;
        in_addr = a;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_hs(input int n);
        int k = 0;
        while (hs_log.size() < n && k < 200) begin
            tick();
            k++;
        end
        chk("hs_wait", 32'(hs_log.size() >= n), 32'd1);
    endtask

    initial begin
        hs_t h0;
        hs_t h1;
        int pc;
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_iteration", iteration, 32'd0);

        // decode and two-cycle latency
        req_ready = 1'b1;
        push(4'd0, 32'hABC1_2345);
        pc = last_push_cyc;
        wait_hs(1);
        h0 = get_hs(0);
        chk("dec_instr", 32'(h0.instr), 32'd0);
        chk("dec_tag", 32'(h0.tag), 32'h0ABC);
        chk("dec_index", 32'(h0.index), 32'h048D);
        chk("dec_offset", 32'(h0.off), 32'h05);
        chk("dec_iter", h0.iter, 32'd0);
        chk("dec_latency", 32'(h0.cyc - pc), 32'd2);

        // back-to-back with a three-cycle stall
        do_reset();
        req_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) push(4'd0, 32'h1234_5000 + 32'(i * 'h41));
            end
            begin
                wait_hs(2);
                req_ready = 1'b0;
                repeat (3) tick();
                req_ready = 1'b1;
            end
        join
        wait_hs(4);
        for (int i = 0; i < 4; i++) begin
            h0 = get_hs(i);
            chk("b2b_iter", h0.iter, 32'(i));
        end
        // fill: one record held at the output plus DEPTH in the FIFO
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(4'd2, 32'h0F00_0000 + 32'(i));
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        tick();
        req_ready = 1'b1;
        push(4'd1, 32'h5555_AAAA);
        wait_hs(10);

        // illegal codes are filtered and counted
        do_reset();
        req_ready = 1'b1;
        push(4'd5, 32'h0000_0100);
        push(4'd7, 32'h0000_0200);
        push(4'd15, 32'h0000_0300);
        push(4'd1, 32'hFEDC_BA98);
        wait_hs(1);
        repeat (4) tick();
        h0 = get_hs(0);
        chk("ill_drop", 32'(drop_count), 32'd3);
        chk("ill_count", 32'(hs_log.size()), 32'd1);
        chk("ill_instr", 32'(h0.instr), 32'd1);
        chk("ill_iter", h0.iter, 32'd0);

        // clear-all quiet period
        do_reset();
        req_ready = 1'b1;
        push(4'd8, 32'h0000_0040);
        push(4'd0, 32'h0001_0080);
        wait_hs(2);
        h0 = get_hs(0);
        h1 = get_hs(1);
        chk("clr_instr0", 32'(h0.instr), 32'd8);
        chk("clr_instr1", 32'(h1.instr), 32'd0);
        chk("clr_iter1", h1.iter, 32'd1);
        chk("clr_gap", 32'(h1.cyc - h0.cyc), 32'(CLEAR_CYCLES + 1));

        // print strobe and iteration wrap
        do_reset();
        force dut.iter_r = 32'hFFFF_FFFF;
        #1;
        release dut.iter_r;
        m_iter = 32'hFFFF_FFFF;
        req_ready = 1'b1;
        push(4'd9, 32'h0000_0000);
        push(4'd0, 32'h0000_0004);
        wait_hs(2);
        repeat (3) tick();
        h0 = get_hs(0);
        h1 = get_hs(1);
        chk("prt_pulses", 32'(pcnt), 32'd1);
        chk("prt_iter0", h0.iter, 32'hFFFF_FFFF);
        chk("prt_iter1", h1.iter, 32'd0);

        // asynchronous reset with a request presented and entries queued
        req_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(4'd1, 32'h7700_0000 + 32'(i));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", 32'(req_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_instr", 32'(instruction), 32'd0);
        chk("arst_tag", 32'(tag), 32'd0);
        chk("arst_iter", iteration, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        req_ready = 1'b1;
        hs_log.delete();
        repeat (5) tick();
        chk("arst_quiet_valid", 32'(req_valid), 32'd0);
        chk("arst_quiet_hs", 32'(hs_log.size()), 32'd0);
        push(4'd4, 32'h0000_1234);
        wait_hs(1);
        h0 = get_hs(0);
        chk("arst_new_instr", 32'(h0.instr), 32'd4);
        chk("arst_new_iter", h0.iter, 32'd0);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/trace_request_sequencer.md
# trace_request_sequencer

Clocked front end for the data cache. Accepts trace records (4-bit command code plus 32-bit byte address) from the trace reader over a valid/ready handshake and buffers them in a small FIFO. It splits each address into tag/index/byte-offset fields and issues one request per handshake to the data cache, stamping each with a monotonically increasing iteration number. It filters illegal command codes, enforces a quiet period after a clear-all (code 8), and pulses a statistics-print strobe for code 9.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `CLEAR_CYCLES`, default 2: idle cycles inserted after a clear-all issue; ≥1.
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: reset, asynchronous assert, active-low. This is the already-decided line: one clock; reset is asynchronous and active-low.
- `in_valid` in, 1: trace record valid.
- `in_ready` out, 1: FIFO can accept.
- `in_cmd` in, 4: trace command code.
- `in_addr` in, 32: byte address.
- `req_valid` out, 1: request presented to cache.
- `req_ready` in, 1: cache accepts request.
- `instruction` out, 4: command code to cache.
- `tag` out, 12: `addr[31:20]`.
- `index` out, 14: `addr[19:6]`.
- `byte_offset` out, 6: `addr[5:0]`.
- `iteration` out, 32: sequence number of the presented request.
- `print_stats` out, 1: one-cycle pulse when a code-9 request handshakes.
- `drop_count` out, 16: number of illegal codes discarded.
- `busy` out, 1: FIFO non-empty or state ≠ IDLE.

## Operation
- **Legal codes:** 0 read, 1 write, 2 instr fetch, 3 invalidate snoop, 4 data-request snoop, 8 clear-all, 9 print.
  - Any other code is accepted at the input handshake but never written to the FIFO.
  - Each such discard increments `drop_count`, which saturates at 0xFFFF.
- **Input handshake:** push occurs on `in_valid && in_ready`. `in_ready = !full`.
  - No pass-through when full, even if a pop happens in the same cycle.
- **FIFO:** `DEPTH` entries of {cmd, addr}. Read/write pointers are `log2(DEPTH)+1` bits, using wrap bit compare for full/empty.
- **State machine:**
  - IDLE: `req_valid=0`. If FIFO is non-empty, load the head into the output register and pop, then go to ISSUE.
  - ISSUE: `req_valid=1`. Outputs are held stable until `req_ready`. On handshake:
    - `iteration` increments; the increment is visible on the next presented request.
    - If the cmd was 8, go to CLEAR_WAIT with counter = `CLEAR_CYCLES`.
    - If the cmd was 9, pulse `print_stats` in the handshake cycle.
    - Otherwise, if the FIFO is non-empty, load and pop the next entry in the same cycle and stay in ISSUE (back-to-back, 1 request/cycle). If it is empty, go to IDLE.
  - CLEAR_WAIT: `req_valid=0`. Counter decrements each cycle. At 0, go to IDLE. The FIFO keeps accepting input.
- **Iteration:** the first request after reset carries 0. It wraps 0xFFFFFFFF→0. Clear-all does not reset it.
- **Address split:** purely bit slicing, no arithmetic.

## Timing
- **Reset values:** `in_ready=1`, `req_valid=0`, `instruction=0`, `tag=0`, `index=0`, `byte_offset=0`, `iteration=0`, `print_stats=0`, `drop_count=0`, `busy=0`. FIFO is empty and state is IDLE.
- **Latency:** a record pushed in cycle N into an empty FIFO while IDLE appears with `req_valid=1` in cycle N+2 (N+1 push visible, N+2 register loaded).
- **Throughput:** one request per cycle while `req_ready=1` and the FIFO is non-empty.
- **Stall:** when `req_valid=1 && !req_ready`, all `req_*` fields are held unchanged.
- **Simultaneous events:**
  - Push and pop in the same cycle leave the count unchanged.
  - An illegal code arriving while full is not accepted (`in_ready=0`) and is not counted until accepted.
- **Reset mid-operation:** asserting `rst_n` low immediately clears all state. The in-flight request and buffered entries are lost.

## Structure
- **Shared package `cache_sim_pkg`:**
  - Command code constants: `CMD_READ=0`, `CMD_WRITE=1`, `CMD_IFETCH=2`, `CMD_INVAL=3`, `CMD_SNOOP_REQ=4`, `CMD_CLEAR=8`, `CMD_PRINT=9`.
  - Field widths: `TAG_W=12`, `INDEX_W=14`, `OFFSET_W=6`.
  - Struct `trace_rec_t` {cmd, addr}.
  - Function `is_legal_cmd`.
- **Sub-module:** one, `sync_fifo` (parameterised width and depth, async active-low reset). The sequencer FSM, address split and counters live in the top module.

## Test plan
- **Decode:** push cmd 0, addr 0xABC12345 with `req_ready=1`. Expect `instruction=0`, `tag=0xABC`, `index=0x048D`, `byte_offset=0x05`, `iteration=0`, two cycles after push.
- **Back-to-back and stall:** push 4 reads with `req_ready=1` for two requests, low for 3 cycles, then high.
  - Expect iterations 0,1,2,3 in order.
  - Fields must be stable during the stall.
  - `in_ready` must drop when 4 entries are held.
- **Illegal codes:** push codes 5, 7, 15, then 1.
  - Expect only the write issued, with `iteration=0`.
  - `drop_count=3`.
- **Clear-all quiet period:** push 8, then 0, with `CLEAR_CYCLES=2`.
  - Expect code 8 to handshake, then `req_valid=0` for exactly 2 cycles, then the read presented with `iteration=1`.
- **Print strobe and wrap:** preload `iteration` to 0xFFFFFFFF by forcing, then push 9 and 0.
  - Expect `print_stats` high exactly one cycle.
  - The next request carries `iteration=0`.
- **Reset mid-operation:** with 3 entries queued and `req_valid=1`, pulse `rst_n` low asynchronously.
  - Expect all outputs at reset values immediately.
  - No request is presented after release until a new push.
